// File: rtl/field_packer.sv
// Packs FIELD_W-bit fields into a DATA_W-bit word at dynamic bit offsets; word is valid 1 cycle after the last-beat handshake.
// Holds the word (in_ready=0) until out_ready retires it, costing one bubble cycle per word.
module field_packer #(
    parameter int DATA_W  = 8,
    parameter int FIELD_W = 3,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIELD_W-1:0] in_field,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_ovf,
    output logic [3:0]         out_count
);

    localparam int CMP_W = (IDX_W > $clog2(DATA_W) + 1) ? IDX_W : $clog2(DATA_W) + 1;
    localparam logic [CMP_W-1:0]  MAX_IDX    = CMP_W'(DATA_W - FIELD_W);
    localparam logic [DATA_W-1:0] FIELD_MASK = {DATA_W{1'b1}} >> (DATA_W - FIELD_W);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                ovf_q, ovf_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_ovf_q, out_ovf_d;
    logic [3:0]          out_count_q, out_count_d;

    logic                accept;
    logic                idx_legal;
    logic [CMP_W-1:0]    idx_ext;
    logic [DATA_W-1:0]   ins_mask;
    logic [DATA_W-1:0]   ins_data;
    logic [DATA_W-1:0]   shadow_upd;
    logic                ovf_upd;
    logic [3:0]          cnt_upd;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    // Shift-and-mask insert; legality is checked before the shift so nothing wraps past the top bit.
    assign idx_ext    = CMP_W'(in_idx);
    assign idx_legal  = (idx_ext <= MAX_IDX);
    assign ins_mask   = FIELD_MASK << in_idx;
    assign ins_data   = DATA_W'(in_field) << in_idx;
    assign shadow_upd = idx_legal ? ((shadow_q & ~ins_mask) | (ins_data & ins_mask)) : shadow_q;
    assign ovf_upd    = ovf_q || !idx_legal;
    assign cnt_upd    = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    shadow_d = shadow_upd;
                    ovf_d    = ovf_upd;
                    cnt_d    = cnt_upd;
                    if (in_last) begin
                        state_d     = HOLD;
                        out_data_d  = shadow_upd;
                        out_ovf_d   = ovf_upd;
                        out_count_d = cnt_upd;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d  = ACCUM;
                    shadow_d = '0;
                    ovf_d    = 1'b0;
                    cnt_d    = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            shadow_q    <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_count_q;

endmodule
